// File: rtl/muldiv_unit_if.sv
// ---------------------------------------------------------------------------
// muldiv_unit_if
// Request/response bundle for the RV32M multiply/divide unit.
//   start  : launch an operation (honoured only while the unit is idle)
//   kill   : abort the in-flight operation (pipeline flush)
//   funct3 : 000 MUL 001 MULH 010 MULHSU 011 MULHU 100 DIV 101 DIVU 110 REM 111 REMU
//   data1  : rs1 (multiplicand / dividend)
//   data2  : rs2 (multiplier / divisor)
//   busy   : unit occupied (computing or presenting a result)
//   valid  : one-cycle pulse, result is valid
//   result : last completed result, held until the next valid
// Modports: master = issuing pipeline stage, slave = muldiv_unit.
// ---------------------------------------------------------------------------
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic            kill;
    logic [2:0]      funct3;
    logic [XLEN-1:0] data1;
    logic [XLEN-1:0] data2;
    logic            busy;
    logic            valid;
    logic [XLEN-1:0] result;

    modport master (
        output start, kill, funct3, data1, data2,
        input  busy, valid, result
    );

    modport slave (
        input  start, kill, funct3, data1, data2,
        output busy, valid, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
// Multi-cycle RV32M multiply/divide unit, XLEN-parametrised.
// Multiplies iterate radix-2 shift-add on operand magnitudes, divides iterate
// restoring division on magnitudes; signs are re-applied when the result is
// captured. Divide-by-zero and signed overflow skip the iteration entirely.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : muldiv_unit_if.slave (start/kill/funct3/data1/data2 in,
//          busy/valid/result out)
//
// Configuration macro:
//   FAST_MUL_EN : when defined, all multiplies use one combinational
//                 2*XLEN-bit multiplier and complete with latency 1.
//                 When undefined, multiplies iterate (latency XLEN+1).
// ---------------------------------------------------------------------------
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic          clk,
    input  logic          rst,
    muldiv_unit_if.slave  bus
);
    localparam int CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN-1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t          state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [2:0]      op_reg;
    logic            neg_reg;
    logic [XLEN-1:0] acc_reg;     // product high half / partial remainder
    logic [XLEN-1:0] lo_reg;      // multiplier -> product low half / dividend -> quotient
    logic [XLEN-1:0] opnd_reg;    // multiplicand / divisor magnitude
    logic [XLEN-1:0] result_reg;

    // ---------------- request decode ----------------
    logic            is_div, a_signed, b_signed, a_neg, b_neg, neg_in;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, div_ovf, fast_hit, bypass, launch;
    logic [XLEN-1:0] bypass_res, fast_res;

    always_comb begin
        is_div   = bus.funct3[2];
        a_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                   (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
        b_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
                   (bus.funct3 == 3'b110);
        a_neg    = a_signed && bus.data1[XLEN-1];
        b_neg    = b_signed && bus.data2[XLEN-1];
        a_mag    = a_neg ? (~bus.data1 + 1'b1) : bus.data1;
        b_mag    = b_neg ? (~bus.data2 + 1'b1) : bus.data2;
        // Remainder follows the dividend sign; everything else is sign xor.
        neg_in   = (bus.funct3 == 3'b110) ? a_neg : (a_neg ^ b_neg);

        div_zero = is_div && (bus.data2 == '0);
        div_ovf  = is_div && !bus.funct3[0] && (bus.data1 == MIN_VAL) &&
                   (bus.data2 == '1);
        launch   = (state_reg == S_IDLE) && bus.start && !bus.kill;
    end

`ifdef FAST_MUL_EN
    logic [2*XLEN-1:0] fa_ext, fb_ext, fast_prod;
    always_comb begin
        // Sign/zero-extend to the full product width; the truncated product
        // is exact modulo 2^(2*XLEN) for every signedness combination.
        fa_ext    = {{XLEN{a_signed && bus.data1[XLEN-1]}}, bus.data1};
        fb_ext    = {{XLEN{b_signed && bus.data2[XLEN-1]}}, bus.data2};
        fast_prod = fa_ext * fb_ext;
        fast_res  = (bus.funct3[1:0] == 2'b00) ? fast_prod[XLEN-1:0]
                                               : fast_prod[2*XLEN-1:XLEN];
        fast_hit  = !is_div;
    end
`else
    always_comb begin
        fast_res = '0;
        fast_hit = 1'b0;
    end
`endif

    always_comb begin
        bypass = div_zero || div_ovf || fast_hit;
        if (div_zero)
            bypass_res = bus.funct3[1] ? bus.data1 : '1;
        else if (div_ovf)
            bypass_res = bus.funct3[1] ? '0 : bus.data1;
        else
            bypass_res = fast_res;
    end

    // ---------------- one iteration ----------------
    logic [XLEN:0]   mul_sum, div_shift;
    logic [XLEN-1:0] div_diff, it_acc, it_lo;
    logic            div_ge;

    always_comb begin
        // Shift-add: add multiplicand when multiplier LSB set, then shift the
        // whole {carry, acc, lo} right by one.
        mul_sum   = {1'b0, acc_reg} + (lo_reg[0] ? {1'b0, opnd_reg} : '0);
        // Restoring: bring in the next dividend bit, subtract if it fits.
        div_shift = {acc_reg, lo_reg[XLEN-1]};
        div_ge    = div_shift >= {1'b0, opnd_reg};
        div_diff  = div_shift[XLEN-1:0] - opnd_reg;
        if (op_reg[2]) begin
            it_acc = div_ge ? div_diff : div_shift[XLEN-1:0];
            it_lo  = {lo_reg[XLEN-2:0], div_ge};
        end else begin
            it_acc = mul_sum[XLEN:1];
            it_lo  = {mul_sum[0], lo_reg[XLEN-1:1]};
        end
    end

    // Final word selection with sign fix-up, applied to the last iteration's
    // outputs so the result is registered on the edge entering DONE.
    logic [2*XLEN-1:0] prod_raw, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, calc_res;

    always_comb begin
        prod_raw = {it_acc, it_lo};
        prod_fix = neg_reg ? (~prod_raw + 1'b1) : prod_raw;
        quo_fix  = neg_reg ? (~it_lo + 1'b1) : it_lo;
        rem_fix  = neg_reg ? (~it_acc + 1'b1) : it_acc;
        if (op_reg[2])
            calc_res = op_reg[1] ? rem_fix : quo_fix;
        else
            calc_res = (op_reg[1:0] == 2'b00) ? prod_fix[XLEN-1:0]
                                              : prod_fix[2*XLEN-1:XLEN];
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_reg <= S_IDLE;
        else
            state_reg <= state_next;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (launch) state_next = bypass ? S_DONE : S_CALC;
            S_CALC: begin
                if (bus.kill)
                    state_next = S_IDLE;
                else if (cnt_reg == CNT_LAST)
                    state_next = S_DONE;
            end
            // DONE always returns to IDLE; a kill here changes nothing since
            // the result is already being presented.
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.busy   = (state_reg != S_IDLE);
        bus.valid  = (state_reg == S_DONE);
        bus.result = result_reg;
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg    <= '0;
            op_reg     <= '0;
            neg_reg    <= 1'b0;
            acc_reg    <= '0;
            lo_reg     <= '0;
            opnd_reg   <= '0;
            result_reg <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (launch) begin
                        op_reg   <= bus.funct3;
                        neg_reg  <= neg_in;
                        cnt_reg  <= '0;
                        acc_reg  <= '0;
                        lo_reg   <= is_div ? a_mag : b_mag;
                        opnd_reg <= is_div ? b_mag : a_mag;
                        if (bypass)
                            result_reg <= bypass_res;
                    end
                end
                S_CALC: begin
                    if (!bus.kill) begin
                        acc_reg <= it_acc;
                        lo_reg  <= it_lo;
                        cnt_reg <= cnt_reg + 1'b1;
                        if (cnt_reg == CNT_LAST)
                            result_reg <= calc_res;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit
// Self-checking bench for muldiv_unit (XLEN=32): directed cases, randomized
// operations against an arithmetic reference model, kill / busy-restart /
// reset-mid-op scenarios.
// ---------------------------------------------------------------------------
module tb_muldiv_unit;
    localparam int XLEN = 32;
    localparam logic [31:0] MIN32 = 32'h8000_0000;
`ifdef FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = XLEN + 1;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    muldiv_unit_if #(.XLEN(XLEN)) bus();
    muldiv_unit #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;
    logic [31:0] last_res;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: plain 64-bit / native signed arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                               input logic [31:0] b);
        longint    sa, sb;
        logic [63:0] ua, ub, p;
        int        ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        ia = $signed(a);
        ib = $signed(b);
        case (f)
            3'd0: begin p = ua * ub;            return p[31:0];  end
            3'd1: begin p = 64'(sa * sb);       return p[63:32]; end
            3'd2: begin p = 64'(sa) * ub;       return p[63:32]; end
            3'd3: begin p = ua * ub;            return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MIN32 && b == 32'hFFFF_FFFF) return a;
                return 32'(ia / ib);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == MIN32 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(ia % ib);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a,
                                       input logic [31:0] b);
        if (f[2] && (b == 0 || (!f[0] && a == MIN32 && b == 32'hFFFF_FFFF)))
            return 1;
        if (!f[2])
            return MUL_LAT;
        return XLEN + 1;
    endfunction

    // Launch one op; latency = edges from the START edge (inclusive) to VALID.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat);
        @(negedge clk);
        bus.funct3 = f;
        bus.data1  = a;
        bus.data2  = b;
        bus.start  = 1'b1;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        // Operands need only be stable on the START edge.
        bus.data1  = $urandom;
        bus.data2  = $urandom;
        bus.funct3 = 3'($urandom);
        lat = 1;
        while (!bus.valid && lat < 80) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = bus.result;
        @(posedge clk);
        #1;
        check("valid_pulse", {63'b0, bus.valid}, 64'd0);
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] sp [5];
        sp[0] = 32'h0; sp[1] = 32'h1; sp[2] = 32'hFFFF_FFFF;
        sp[3] = MIN32; sp[4] = 32'h7FFF_FFFF;
        if ($urandom_range(0, 3) == 0)
            return sp[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "simulation timeout");
    end

    logic [2:0]  d_f   [12];
    logic [31:0] d_a   [12];
    logic [31:0] d_b   [12];
    logic [31:0] d_exp [12];
    int          d_lat [12];

    initial begin
        logic [31:0] res, exp_res;
        int lat, vcount;

        d_f[0]=3'd0;  d_a[0]=32'd7;          d_b[0]=32'hFFFF_FFFD; d_exp[0]=32'hFFFF_FFEB; d_lat[0]=MUL_LAT;
        d_f[1]=3'd1;  d_a[1]=MIN32;          d_b[1]=MIN32;         d_exp[1]=32'h4000_0000; d_lat[1]=MUL_LAT;
        d_f[2]=3'd3;  d_a[2]=32'hFFFF_FFFF;  d_b[2]=32'hFFFF_FFFF; d_exp[2]=32'hFFFF_FFFE; d_lat[2]=MUL_LAT;
        d_f[3]=3'd2;  d_a[3]=32'hFFFF_FFFF;  d_b[3]=32'hFFFF_FFFF; d_exp[3]=32'hFFFF_FFFF; d_lat[3]=MUL_LAT;
        d_f[4]=3'd4;  d_a[4]=32'hFFFF_FFF9;  d_b[4]=32'd2;         d_exp[4]=32'hFFFF_FFFD; d_lat[4]=33;
        d_f[5]=3'd6;  d_a[5]=32'hFFFF_FFF9;  d_b[5]=32'd2;         d_exp[5]=32'hFFFF_FFFF; d_lat[5]=33;
        d_f[6]=3'd5;  d_a[6]=32'd100;        d_b[6]=32'd7;         d_exp[6]=32'd14;        d_lat[6]=33;
        d_f[7]=3'd7;  d_a[7]=32'd100;        d_b[7]=32'd7;         d_exp[7]=32'd2;         d_lat[7]=33;
        d_f[8]=3'd4;  d_a[8]=32'd5;          d_b[8]=32'd0;         d_exp[8]=32'hFFFF_FFFF; d_lat[8]=1;
        d_f[9]=3'd7;  d_a[9]=32'd5;          d_b[9]=32'd0;         d_exp[9]=32'd5;         d_lat[9]=1;
        d_f[10]=3'd4; d_a[10]=MIN32;         d_b[10]=32'hFFFF_FFFF; d_exp[10]=MIN32;       d_lat[10]=1;
        d_f[11]=3'd6; d_a[11]=MIN32;         d_b[11]=32'hFFFF_FFFF; d_exp[11]=32'h0;       d_lat[11]=1;

        rst = 1'b1;
        bus.start = 1'b0; bus.kill = 1'b0; bus.funct3 = 3'd0;
        bus.data1 = '0;   bus.data2 = '0;
        #1;
        check("rst_busy",   {63'b0, bus.busy},  64'd0);
        check("rst_valid",  {63'b0, bus.valid}, 64'd0);
        check("rst_result", {32'b0, bus.result}, 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases
        for (int i = 0; i < 12; i++) begin
            run_op(d_f[i], d_a[i], d_b[i], res, lat);
            $display("directed f=%0d a=%h b=%h res=%h exp=%h lat=%0d", d_f[i], d_a[i], d_b[i], res, d_exp[i], lat);
            check("dir_result", {32'b0, res}, {32'b0, d_exp[i]});
            check("dir_latency", 64'(lat), 64'(d_lat[i]));
            last_res = d_exp[i];
        end

        // Randomized against the reference model
        for (int i = 0; i < 80; i++) begin
            logic [2:0]  f;
            logic [31:0] a, b;
            f = 3'($urandom);
            a = pick_operand();
            b = pick_operand();
            exp_res = ref_result(f, a, b);
            run_op(f, a, b, res, lat);
            $display("random f=%0d a=%h b=%h res=%h exp=%h lat=%0d", f, a, b, res, exp_res, lat);
            check("rnd_result", {32'b0, res}, {32'b0, exp_res});
            check("rnd_latency", 64'(lat), 64'(ref_latency(f, a, b)));
            last_res = exp_res;
        end

        // KILL in the 10th CALC cycle of a DIVU
        @(negedge clk);
        bus.funct3 = 3'd5; bus.data1 = 32'd1000; bus.data2 = 32'd3; bus.start = 1'b1;
        @(posedge clk); #1; bus.start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        check("kill_busy_before", {63'b0, bus.busy}, 64'd1);
        bus.kill = 1'b1;
        @(posedge clk); #1; bus.kill = 1'b0;
        check("kill_busy_after", {63'b0, bus.busy}, 64'd0);
        vcount = 0;
        repeat (40) begin @(posedge clk); #1; if (bus.valid) vcount++; end
        $display("kill divu valid_count=%0d result=%h", vcount, bus.result);
        check("kill_no_valid", 64'(vcount), 64'd0);
        check("kill_hold", {32'b0, bus.result}, {32'b0, last_res});

        // KILL with START in IDLE: op must not launch
        @(negedge clk);
        bus.funct3 = 3'd5; bus.data1 = 32'd9; bus.data2 = 32'd2;
        bus.start = 1'b1; bus.kill = 1'b1;
        @(posedge clk); #1; bus.start = 1'b0; bus.kill = 1'b0;
        check("killstart_busy", {63'b0, bus.busy}, 64'd0);
        vcount = 0;
        repeat (36) begin @(posedge clk); #1; if (bus.valid) vcount++; end
        $display("kill+start valid_count=%0d", vcount);
        check("killstart_no_valid", 64'(vcount), 64'd0);

        // START while busy (mid-CALC and in DONE) is ignored
        @(negedge clk);
        bus.funct3 = 3'd5; bus.data1 = 32'd1000; bus.data2 = 32'd3; bus.start = 1'b1;
        @(posedge clk); #1; bus.start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        bus.funct3 = 3'd0; bus.data1 = 32'd2; bus.data2 = 32'd2; bus.start = 1'b1;
        @(posedge clk); #1; bus.start = 1'b0;
        vcount = 0;
        res = '0;
        repeat (70) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (bus.valid) begin
                vcount++;
                res = bus.result;
                bus.start = 1'b1;   // attempt restart during DONE
            end
        end
        $display("busy restart valid_count=%0d result=%h", vcount, res);
        check("busy_one_valid", 64'(vcount), 64'd1);
        check("busy_result", {32'b0, res}, 64'd333);

        // Asynchronous reset mid-CALC
        @(negedge clk);
        bus.funct3 = 3'd3; bus.data1 = 32'h1234_5678; bus.data2 = 32'h9ABC_DEF0; bus.start = 1'b1;
        @(posedge clk); #1; bus.start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        #2;
        rst = 1'b1;
        #1;
        $display("reset mid-op busy=%0d valid=%0d result=%h", bus.busy, bus.valid, bus.result);
        check("midrst_busy",   {63'b0, bus.busy},  64'd0);
        check("midrst_valid",  {63'b0, bus.valid}, 64'd0);
        check("midrst_result", {32'b0, bus.result}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(3'd7, 32'd100, 32'd7, res, lat);
        $display("after reset f=7 res=%h lat=%0d", res, lat);
        check("postrst_result", {32'b0, res}, 64'd2);
        check("postrst_latency", 64'(lat), 64'd33);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
